// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state encoding and instruction size for the fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small shift-style FIFO; head is entry 0 and reads as zero when empty
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    localparam int IW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic do_push, do_pop;
    logic [IW-1:0] wr_idx;
    assign do_pop = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign wr_idx = IW'(count - CW'(do_pop));
    assign head = count != '0 ? mem[0] : '0;
    // occupancy; flush empties the queue without touching storage
    always_ff @(posedge clk)
        if (rst || flush) count <= '0;
        else count <= count + CW'(do_push) - CW'(do_pop);
    // entries slide toward the head on pop; a push lands just behind the last survivor
    always_ff @(posedge clk) begin
        if (do_pop) for (int i = 0; i < DEPTH - 1; i++) mem[IW'(i)] <= mem[IW'(i + 1)];
        if (do_push) mem[wr_idx] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a small instruction queue; FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pcplus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_state_t state;
    logic [31:0] pc;
    logic [CW-1:0] count;
    logic [CW:0] count_next;
    logic [63:0] head;
    logic push, pop, can_start, room;
    assign push = state == WAIT && imem_ack && !redirect;
    assign pop = out_valid && !stall && !redirect;
    assign count_next = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
    assign can_start = {1'b0, count} < (CW + 1)'(DEPTH) && !redirect;
    assign room = count_next < (CW + 1)'(DEPTH);
    assign imem_req = state != IDLE;
    assign out_valid = count != '0;
    assign {out_inst, out_pcplus4} = head;
    // fetch FSM; imem_addr is held separately from pc so a redirect in DROP cannot disturb the open request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            pc <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: state <= can_start ? WAIT : IDLE;
                WAIT: state <= redirect ? (imem_ack ? IDLE : DROP) : (!imem_ack || room) ? WAIT : IDLE;
                DROP: state <= imem_ack ? IDLE : DROP;
                default: state <= IDLE;
            endcase
            if (redirect) pc <= {redirect_pc[31:2], 2'b00};
            else if (push) pc <= pc + INSTR_BYTES;
            if (state == IDLE && can_start) imem_addr <= pc;
            else if (push && room) imem_addr <= pc + INSTR_BYTES;
        end
    end
    fetch_queue #(.DEPTH(DEPTH), .WIDTH(64)) u_queue (
        .clk(CLK),
        .rst(RESET),
        .push(push),
        .pop(pop),
        .flush(redirect),
        .din({imem_data, pc + INSTR_BYTES}),
        .head(head),
        .count(count)
    );
`ifdef FETCH_PERF_EN
    // pushes and stalled-output cycles, free-running modulo 2^32
    always_ff @(posedge CLK)
        if (RESET) begin
            perf_fetched <= '0;
            perf_stall <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_stall <= perf_stall + 32'(out_valid && stall);
        end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency/grant-limited memory model
module tb_fetch_unit;
    logic CLK = 0, RESET = 1, redirect = 0, stall = 0, force_ack = 0;
    logic imem_req, imem_ack, out_valid;
    logic [31:0] imem_addr, imem_data, out_inst, out_pcplus4;
    logic [31:0] redirect_pc = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif
    int checks = 0, errors = 0;
    int lat = 0, wcnt = 0, acks = 0, grant_limit = 0;
    logic [63:0] sb [$];
    logic hold = 0;
    logic [31:0] held_addr = 0;

    fetch_unit dut (
        .CLK(CLK), .RESET(RESET),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_inst(out_inst), .out_pcplus4(out_pcplus4)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    assign imem_ack = force_ack || (imem_req && acks < grant_limit && wcnt >= lat);
    assign imem_data = imem_addr ^ 32'h5A5A_0000;

    always @(posedge CLK) begin
        if (RESET) wcnt <= 0;
        else if (imem_ack) begin
            wcnt <= 0;
            acks <= acks + 1;
        end else if (imem_req) wcnt <= wcnt + 1;
    end

    function automatic logic [63:0] ent(logic [31:0] a);
        return {a ^ 32'h5A5A_0000, a + 32'd4};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(negedge CLK);
            if (hold && imem_req) begin
                checks++;
                if (imem_addr !== held_addr) begin
                    errors++;
                    $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, held_addr);
                end
            end
            hold = imem_req && !imem_ack && !RESET;
            held_addr = imem_addr;
            if (!RESET && out_valid && !stall && !redirect) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got inst=%h pcplus4=%h, required nothing", out_inst, out_pcplus4);
                end else begin
                    logic [63:0] ex;
                    ex = sb.pop_front();
                    if ({out_inst, out_pcplus4} !== ex) begin
                        errors++;
                        $display("FAIL scoreboard: got inst=%h pcplus4=%h, required inst=%h pcplus4=%h",
                                 out_inst, out_pcplus4, ex[63:32], ex[31:0]);
                    end
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1;
        stall = 0;
        redirect = 0;
        force_ack = 0;
        tick(2);
        sb.delete();
    endtask

    task automatic test_reset();
        RESET = 1;
        force_ack = 1;
        redirect = 1;
        redirect_pc = 32'h1234;
        tick(2);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h required 0", out_inst); end
        checks++; if (out_pcplus4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4: got %h required 0", out_pcplus4); end
        force_ack = 0;
        redirect = 0;
        grant_limit = acks;
        RESET = 0;
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_fetch: req=%b addr=%h required req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 0;
        grant_limit = acks + 6;
        for (int i = 0; i < 6; i++) sb.push_back(ent(32'(4 * i)));
        RESET = 0;
        tick(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b required 0", out_valid); end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL stream_first_req: req=%b addr=%h required req=1 addr=00000000", imem_req, imem_addr);
        end
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            checks++;
            if (out_valid !== 1'b1 || out_pcplus4 !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_seq: valid=%b pcplus4=%h required valid=1 pcplus4=%h", out_valid, out_pcplus4, 32'(4 * i));
            end
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left required 0", sb.size()); end
        tick(2);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pcplus4 !== 32'h0) begin
            errors++;
            $display("FAIL empty_outputs: valid=%b inst=%h pcplus4=%h required all 0", out_valid, out_inst, out_pcplus4);
        end
    endtask

    task automatic test_stall();
        int base;
        do_reset();
        lat = 0;
        grant_limit = acks + 8;
        for (int i = 0; i < 8; i++) sb.push_back(ent(32'(4 * i)));
        stall = 1;
        base = acks;
        RESET = 0;
        tick(5);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b required 0", imem_req); end
        checks++; if (acks - base != 2) begin errors++; $display("FAIL stall_depth: got %0d fetched required 2", acks - base); end
        checks++;
        if (out_valid !== 1'b1 || out_pcplus4 !== 32'h4) begin
            errors++;
            $display("FAIL stall_head: valid=%b pcplus4=%h required valid=1 pcplus4=00000004", out_valid, out_pcplus4);
        end
        stall = 0;
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: %0d left required 0", sb.size()); end
        tick(3);
    endtask

    task automatic test_redirect_wait(int l, bit twice);
        int n;
        do_reset();
        lat = l;
        grant_limit = acks + 5;
        sb.push_back(ent(32'h0));
        sb.push_back(ent(32'h4));
        sb.push_back(ent(32'h40));
        sb.push_back(ent(32'h44));
        RESET = 0;
        n = 0;
        while (!(imem_req && imem_addr == 32'h8) && n < 40) begin tick(1); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL rw_timeout: addr=%h required 00000008", imem_addr); end
        tick(1);
        checks++; if (imem_ack !== 1'b0) begin errors++; $display("FAIL rw_ack_early: got %b required 0", imem_ack); end
        redirect = 1;
        redirect_pc = twice ? 32'h80 : 32'h40;
        tick(1);
        if (twice) begin
            redirect_pc = 32'h40;
            tick(1);
        end
        redirect = 0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_drop: req=%b addr=%h valid=%b required req=1 addr=00000008 valid=0", imem_req, imem_addr, out_valid);
        end
        n = 0;
        while (!out_valid && n < 40) begin tick(1); n++; end
        checks++;
        if (out_pcplus4 !== 32'h44) begin
            errors++;
            $display("FAIL rw_next: pcplus4=%h required 00000044", out_pcplus4);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rw_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_redirect_ack();
        int n;
        do_reset();
        lat = 1;
        grant_limit = acks + 6;
        for (int i = 0; i < 3; i++) sb.push_back(ent(32'(4 * i)));
        sb.push_back(ent(32'h100));
        sb.push_back(ent(32'h104));
        RESET = 0;
        n = 0;
        while (!(imem_req && imem_addr == 32'hC && imem_ack) && n < 40) begin tick(1); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL ra_timeout: addr=%h required 0000000c", imem_addr); end
        redirect = 1;
        redirect_pc = 32'h100;
        tick(1);
        redirect = 0;
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ra_idle: req=%b valid=%b required req=0 valid=0", imem_req, out_valid);
        end
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL ra_refetch: req=%b addr=%h required req=1 addr=00000100", imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ra_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset();
        lat = 3;
        grant_limit = acks + 10;
        sb.push_back(ent(32'h0));
        RESET = 0;
        n = 0;
        while (!(imem_req && imem_addr == 32'h4 && !imem_ack) && n < 40) begin tick(1); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL rm_timeout: addr=%h required 00000004", imem_addr); end
        RESET = 1;
        force_ack = 1;
        tick(1);
        force_ack = 0;
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_abandon: req=%b valid=%b required req=0 valid=0", imem_req, out_valid);
        end
        tick(1);
        sb.delete();
        grant_limit = acks + 1;
        sb.push_back(ent(32'h0));
        RESET = 0;
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rm_restart: req=%b addr=%h required req=1 addr=00000000", imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rm_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 0;
        grant_limit = acks + 3;
        sb.push_back(ent(32'hFFFF_FFF8));
        sb.push_back(ent(32'hFFFF_FFFC));
        sb.push_back(ent(32'h0));
        redirect = 1;
        redirect_pc = 32'hFFFF_FFF8;
        RESET = 0;
        tick(1);
        redirect = 0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle: req=%b required 0", imem_req); end
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_req: req=%b addr=%h required req=1 addr=fffffff8", imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left required 0", sb.size()); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
            errors++;
            $display("FAIL perf_reset: fetched=%0d stall=%0d required 0 0", perf_fetched, perf_stall);
        end
        lat = 0;
        grant_limit = acks + 10;
        for (int i = 0; i < 10; i++) sb.push_back(ent(32'(4 * i)));
        RESET = 0;
        tick(3);
        stall = 1;
        tick(3);
        stall = 0;
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick(1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL perf_drain: %0d left required 0", sb.size()); end
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched: got %0d required 10", perf_fetched); end
        checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d required 3", perf_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait(2, 1'b0);
        test_redirect_wait(4, 1'b1);
        test_redirect_ack();
        test_reset_mid_wait();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
